// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a standard-mode FIFO (one-cycle read latency)
// into a ready/valid stream through a 2-entry skid buffer.
// Optional statistics counters (word_cnt, stall_cnt) are built only when
// the macro FIFO_RD_STATS_EN is defined; the default build omits them.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

  occ_t                  state_q, state_d;
  logic                  pending;
  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic                  pop, cap;
  logic [2:0]            room;

  assign pop = m_tvalid && m_tready;
  // the word requested last cycle is on fifo_dout now
  assign cap = pending;

  // Words already owned after this cycle's pop; read only if a slot stays
  // free. Pending counts as owned so the buffer can never overflow.
  assign room       = {1'b0, state_q} + {2'b00, pending} - {2'b00, pop};
  assign fifo_rd_en = !srst && !fifo_empty && (room < 3'd2);

  // occupancy state and in-flight flag
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= EMPTY;
      pending <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= fifo_rd_en;
    end
  end

  // occupancy moves +1 on capture, -1 on pop, holds when both happen
  always_comb begin
    state_d = state_q;
    if (cap && !pop)
      state_d = (state_q == EMPTY) ? ONE : FULL;
    else if (!cap && pop)
      state_d = (state_q == FULL) ? ONE : EMPTY;
  end

  // stream outputs; forced quiet while reset is held
  always_comb begin
    m_tvalid = !srst && (state_q != EMPTY);
    m_tdata  = srst ? '0 : head_q;
  end

  // buffer datapath: head is what the stream shows, tail is the spill slot
  always_ff @(posedge clk) begin
    if (srst) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (cap && pop) begin
      if (state_q == FULL) begin
        head_q <= tail_q;
        tail_q <= fifo_dout;
      end else begin
        head_q <= fifo_dout;
      end
    end else if (cap) begin
      if (state_q == EMPTY) head_q <= fifo_dout;
      else                  tail_q <= fifo_dout;
    end else if (pop) begin
      head_q <= tail_q;
    end
  end

`ifdef FIFO_RD_STATS_EN
  // beat counter wraps; stall counter sticks at all ones
  always_ff @(posedge clk) begin
    if (srst) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) word_cnt <= word_cnt + 1'b1;
      if (m_tvalid && !m_tready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench for fifo_stream_reader with a
// behavioural standard-mode FIFO and an in-order golden queue.
// Define FIFO_RD_STATS_EN to also exercise the statistics counters.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       srst;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] word_cnt, stall_cnt;
  logic        fifo_rd_en4, m_tvalid4;
  logic [7:0]  m_tdata4;
  logic [3:0]  word_cnt4, stall_cnt4;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .srst(srst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready)
`ifdef FIFO_RD_STATS_EN
    , .word_cnt(word_cnt), .stall_cnt(stall_cnt)
`endif
  );

`ifdef FIFO_RD_STATS_EN
  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .srst(srst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en4), .m_tdata(m_tdata4), .m_tvalid(m_tvalid4),
    .m_tready(m_tready), .word_cnt(word_cnt4), .stall_cnt(stall_cnt4)
  );
`endif

  logic [7:0] q[$];     // FIFO contents not yet read
  logic [7:0] gold[$];  // words read from the FIFO, not yet delivered
  bit         rd_l, srst_l;
  int         n_chk, n_fail, beats, reads;
  logic [7:0] last_beat, exp_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sett();
    fifo_empty = (q.size() == 0);
    #1;
  endtask

  // one clock: observe/score, let the edge happen, then play FIFO read data
  task automatic tick();
    sett();
    if (m_tvalid && m_tready) begin
      beats++;
      last_beat = m_tdata;
      if (gold.size() == 0) chk("beat_unexpected", 1, 0);
      else                  chk("beat_order", m_tdata, gold.pop_front());
    end
    chk("rd_while_empty", fifo_rd_en && fifo_empty, 0);
    rd_l   = fifo_rd_en;
    srst_l = srst;
    @(negedge clk);
    if (srst_l) gold.delete();
    if (rd_l) begin
      if (q.size() == 0) chk("read_underflow", 1, 0);
      else begin
        fifo_dout = q.pop_front();
        gold.push_back(fifo_dout);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    m_tready = 1'b1;
    while ((q.size() != 0 || gold.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, q.size() + gold.size(), 0);
  endtask

  bit   [5:0] e_rd = 6'b000111;
  bit   [5:0] e_vl = 6'b011100;
  logic [7:0] e_dt [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    srst = 1'b1; m_tready = 1'b0; fifo_dout = '0; fifo_empty = 1'b1;
    n_chk = 0; n_fail = 0; beats = 0;
    repeat (3) tick();
    sett();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_tdata", m_tdata, 0);
    srst = 1'b0;

    // preloaded 3 words, ready held high
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sett();
      chk("s1_rd_en", fifo_rd_en, e_rd[i]);
      chk("s1_tvalid", m_tvalid, e_vl[i]);
      if (e_vl[i]) chk("s1_tdata", m_tdata, e_dt[i]);
      tick();
    end

    // 512 back-to-back words
    beats = 0;
    repeat (512) q.push_back(8'($urandom));
    for (int i = 0; i < 514; i++) tick();
    chk("s2_beats", beats, 512);
    sett();
    chk("s2_idle", m_tvalid, 0);

    // backpressure: exactly two reads, head held, then no-gap resume
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) q.push_back(8'(8'h50 + k));
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      sett();
      if (i >= 2) begin
        chk("s3_hold_valid", m_tvalid, 1);
        chk("s3_hold_data", m_tdata, 8'h50);
      end
      tick();
      reads += int'(rd_l);
    end
    chk("s3_reads", reads, 2);
    chk("s3_fifo_left", q.size(), 3);
    m_tready = 1'b1;
    beats = 0;
    repeat (5) tick();
    chk("s3_resume_beats", beats, 5);
    sett();
    chk("s3_idle", m_tvalid, 0);

    // reset while FULL
    m_tready = 1'b0;
    for (int k = 0; k < 10; k++) q.push_back(8'(8'hA0 + k));
    repeat (4) tick();
    sett();
    chk("s5_full_data", m_tdata, 8'hA0);
    srst = 1'b1;
    sett();
    chk("s5_rst_valid", m_tvalid, 0);
    chk("s5_rst_rd_en", fifo_rd_en, 0);
    chk("s5_rst_tdata", m_tdata, 0);
    tick();
    srst = 1'b0;
    sett();
    chk("s5_post_valid", m_tvalid, 0);
    chk("s5_post_rd_en", fifo_rd_en, 1);
    m_tready = 1'b1;
    beats = 0; n = 0;
    while (beats == 0 && n < 10) begin tick(); n++; end
    chk("s5_first_seen", beats, 1);
    chk("s5_first_word", last_beat, 8'hA2);

    // reset mid-stream with a read in flight
    repeat (3) tick();
    exp_h = q[0];
    srst = 1'b1;
    tick();
    srst = 1'b0;
    beats = 0; n = 0;
    while (beats == 0 && n < 10) begin tick(); n++; end
    chk("s5b_first_seen", beats, 1);
    chk("s5b_first_word", last_beat, exp_h);
    drain("s5_drain");

    // sparse writer, random backpressure
    beats = 0;
    for (int i = 0; i < 40000; i++) begin
      if (i % 4 == 0) q.push_back(8'($urandom));
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("s4_drain");
    chk("s4_beats", beats, 10000);

`ifdef FIFO_RD_STATS_EN
    srst = 1'b1;
    tick();
    srst = 1'b0;
    sett();
    chk("s6_rst_word", word_cnt, 0);
    chk("s6_rst_stall", stall_cnt, 0);
    for (int k = 0; k < 100; k++) q.push_back(8'(k));
    beats = 0; n = 0;
    while (beats < 100 && n < 300) begin
      m_tready = !(n >= 10 && n < 17);
      tick();
      n++;
    end
    sett();
    chk("s6_word_cnt", word_cnt, 100);
    chk("s6_stall_cnt", stall_cnt, 7);
    chk("s6_word_cnt4", word_cnt4, 4);
    chk("s6_stall_cnt4", stall_cnt4, 7);
    q.push_back(8'hEE);
    m_tready = 1'b0;
    repeat (25) tick();
    sett();
    chk("s6_stall_cnt_more", stall_cnt, 30);
    chk("s6_stall_cnt4_sat", stall_cnt4, 15);
    drain("s6_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
